pkt_parser_gen: RTL and testbench
=================================

Name: pkt_parser_gen

Overview:
- Parametrised byte-stream frame parser; next generation of the team's fixed-format packet state machine.
- Finds preamble+SFD, then walks TYPE, LEN, DATA and FCS fields; forwards frame bytes from TYPE to last FCS byte with sop/eop framing.
- New over the previous block: input valid qualifier with stall, configurable preamble/length/FCS sizes, oversize-length abort with error flag, zero-length frames, good-frame counter.
- Sits between the byte deserialiser and the packet buffer/CRC checker.

Parameters:
PRE_NUM, 7, minimum consecutive PRE_BYTE values before SFD (1..15)
PRE_BYTE, 8'h55, preamble byte value
SFD_BYTE, 8'hD5, start-of-frame delimiter value
LEN_BYTES, 2, LEN field bytes, big-endian (1..2)
FCS_BYTES, 4, FCS field bytes (1..8)
CTRL_PKT_LEN, 64, DATA bytes of a TYPE==0 (control) frame
MAX_LEN, 1500, largest legal LEN value; must be < 2^(8*LEN_BYTES)

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
din  in  8  input byte
din_vld  in  1  din qualifier; 0 = stall
state_c  out  3  current state (debug)
dout  out  8  forwarded byte
dout_vld  out  1  dout qualifier
dout_sop  out  1  first frame byte (TYPE)
dout_eop  out  1  last frame byte
dout_err  out  1  frame aborted; only asserted together with dout_eop
pkt_cnt  out  16  good frames completed, wraps 16'hFFFF->0

Behaviour:
- Reset (rst_n=0, asynchronous, any time incl. mid-frame): state_c=HEAD, all counters 0, dout=0, dout_vld/sop/eop/err=0, pkt_cnt=0. No eop is produced for the truncated frame.
- States: HEAD=0, TYPE=1, LEN=2, DATA=3, FCS=4. All state/counter updates happen only on cycles with din_vld=1; din_vld=0 holds everything.
- HEAD: pre_cnt counts consecutive PRE_BYTE, saturating at PRE_NUM. SFD_BYTE with pre_cnt>=PRE_NUM -> TYPE, pre_cnt<=0. SFD with pre_cnt<PRE_NUM -> pre_cnt<=0. Any other byte -> pre_cnt<=0. Extra preamble bytes beyond PRE_NUM are accepted.
- TYPE: din==0 -> DATA, remaining<=CTRL_PKT_LEN. Else -> LEN, len_idx<=0.
- LEN: len_reg<={len_reg,din} (8*LEN_BYTES bits). On byte LEN_BYTES-1 the full value v is evaluated: v>MAX_LEN -> HEAD (abort); v==0 -> FCS; else -> DATA, remaining<=v.
- DATA: remaining decrements per byte; byte with remaining==1 -> FCS, fcs_idx<=0.
- FCS: fcs_idx increments; byte with fcs_idx==FCS_BYTES-1 -> HEAD.
- Outputs registered, latency 1 cycle from din sample:
  - dout<=din on every din_vld=1 cycle, otherwise held.
  - dout_vld<=din_vld && state_c!=HEAD (preamble/SFD not forwarded).
  - dout_sop<=din_vld && state_c==TYPE.
  - dout_eop<=din_vld && (last FCS byte || aborting LEN byte).
  - dout_err<=din_vld && aborting LEN byte.
  - pkt_cnt increments on the same edge as a non-error eop.
- sop/eop/err are single-cycle pulses; after a stall they reassert only on the next valid byte.
- Minimum frame: control frame = 1+CTRL_PKT_LEN+FCS_BYTES bytes; zero-length data frame = 1+LEN_BYTES+FCS_BYTES bytes.
- Back-to-back frames: the preamble of the next frame may start on the byte after the last FCS byte.

Decomposition:
- Package pkt_parser_pkg: state encodings HEAD..FCS, state width 3, PRE_BYTE/SFD_BYTE defaults.
- One sub-module: pkt_preamble_det (pre_cnt, saturating count, SFD match; output sfd_hit pulse). The main FSM, field counters and output registers stay in pkt_parser_gen.

Test Plan:
- 7x55,D5,TYPE=00,64 data,4 FCS -> sop on TYPE byte (dout=00), 69 dout_vld cycles, eop on 4th FCS byte, pkt_cnt=1.
- 8x55,D5,TYPE=01,LEN=00 05,5 data,4 FCS with din_vld toggling 1/0 -> 12 valid output bytes, eop on the last, no output during stalls, pkt_cnt=1.
- 6x55,D5 then 7x55,D5,TYPE=00... -> first SFD rejected (state stays HEAD, no dout_vld); second frame parses normally.
- TYPE=02,LEN=07 00 (1792>1500) -> eop+err on second LEN byte, state HEAD next cycle, pkt_cnt unchanged.
- TYPE=03,LEN=00 00, 4 FCS -> DATA skipped; sop,2 LEN bytes,4 FCS bytes then eop (7 bytes total), pkt_cnt+1.
- rst_n low during DATA byte 10 of a 64-byte frame -> all outputs 0 immediately, state_c=0, no eop; a following full frame parses correctly with pkt_cnt=1.

Source files
------------

// File: rtl/pkt_parser_pkg.sv
`default_nettype none
// ============================================================================
// Module   : pkt_parser_pkg
// Brief    : Shared state encodings and default byte values for the
//            parametrised frame parser.
// Revision : 1.0 - initial release
// ============================================================================
package pkt_parser_pkg;

    localparam int c_STATE_W = 3;

    typedef enum logic [c_STATE_W-1:0] {
        S_HEAD = 3'd0,
        S_TYPE = 3'd1,
        S_LEN  = 3'd2,
        S_DATA = 3'd3,
        S_FCS  = 3'd4
    } state_t;

    localparam logic [7:0] c_PRE_BYTE_DEF = 8'h55;
    localparam logic [7:0] c_SFD_BYTE_DEF = 8'hD5;

endpackage
`default_nettype wire

// File: rtl/pkt_preamble_det.sv
`default_nettype none
// ============================================================================
// Module   : pkt_preamble_det
// Brief    : Counts consecutive preamble bytes (saturating) and flags an SFD
//            that follows a long enough preamble run.
// Revision : 1.0 - initial release
// ============================================================================
module pkt_preamble_det
    import pkt_parser_pkg::*;
#(
    parameter int         PRE_NUM  = 7,
    parameter logic [7:0] PRE_BYTE = c_PRE_BYTE_DEF,
    parameter logic [7:0] SFD_BYTE = c_SFD_BYTE_DEF
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       i_en,
    input  logic [7:0] i_din,
    output logic       o_sfd_hit
);

    localparam logic [3:0] c_PRE_NUM = 4'(PRE_NUM);

    logic [3:0] r_pre_cnt;
    logic       w_pre_sat;

    assign w_pre_sat = (r_pre_cnt >= c_PRE_NUM);
    assign o_sfd_hit = i_en && (i_din == SFD_BYTE) && w_pre_sat;

    // Run length of preamble bytes; any non-preamble byte (SFD included) restarts it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pre_cnt <= '0;
        end else if (i_en) begin
            if (i_din == PRE_BYTE) begin
                if (!w_pre_sat) begin
                    r_pre_cnt <= r_pre_cnt + 4'd1;
                end
            end else begin
                r_pre_cnt <= '0;
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/pkt_parser_gen.sv
`default_nettype none
// ============================================================================
// Module   : pkt_parser_gen
// Brief    : Byte-stream frame parser. Locks on preamble+SFD, walks TYPE, LEN,
//            DATA and FCS fields and forwards TYPE..FCS with sop/eop/err
//            framing. Oversize LEN aborts the frame with err on eop.
// Revision : 1.0 - initial release
// ============================================================================
module pkt_parser_gen
    import pkt_parser_pkg::*;
#(
    parameter int         PRE_NUM      = 7,
    parameter logic [7:0] PRE_BYTE     = c_PRE_BYTE_DEF,
    parameter logic [7:0] SFD_BYTE     = c_SFD_BYTE_DEF,
    parameter int         LEN_BYTES    = 2,
    parameter int         FCS_BYTES    = 4,
    parameter int         CTRL_PKT_LEN = 64,
    parameter int         MAX_LEN      = 1500
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [7:0]  din,
    input  logic        din_vld,
    output logic [2:0]  state_c,
    output logic [7:0]  dout,
    output logic        dout_vld,
    output logic        dout_sop,
    output logic        dout_eop,
    output logic        dout_err,
    output logic [15:0] pkt_cnt
);

    localparam int c_LEN_W  = 8 * LEN_BYTES;
    localparam int c_LIDX_W = (LEN_BYTES > 1) ? $clog2(LEN_BYTES) : 1;
    localparam int c_FIDX_W = (FCS_BYTES > 1) ? $clog2(FCS_BYTES) : 1;
    localparam logic [c_LIDX_W-1:0] c_LIDX_LAST = c_LIDX_W'(LEN_BYTES - 1);
    localparam logic [c_FIDX_W-1:0] c_FIDX_LAST = c_FIDX_W'(FCS_BYTES - 1);
    localparam logic [15:0]         c_CTRL_LEN  = 16'(CTRL_PKT_LEN);
    localparam logic [31:0]         c_MAX_LEN   = 32'(MAX_LEN);

    state_t                r_state;
    state_t                w_state_nxt;
    logic [c_LEN_W-1:0]    w_len_val;
    logic [31:0]           w_len_val32;
    logic [c_LIDX_W-1:0]   r_len_idx;
    logic [c_FIDX_W-1:0]   r_fcs_idx;
    logic [15:0]           r_remaining;
    logic                  w_sfd_hit;
    logic                  w_len_last;
    logic                  w_abort;
    logic                  w_fcs_last;

    pkt_preamble_det #(
        .PRE_NUM  (PRE_NUM),
        .PRE_BYTE (PRE_BYTE),
        .SFD_BYTE (SFD_BYTE)
    ) u_pre_det (
        .clk       (clk),
        .rst_n     (rst_n),
        .i_en      (din_vld && (r_state == S_HEAD)),
        .i_din     (din),
        .o_sfd_hit (w_sfd_hit)
    );

    // LEN value as it stands including the current byte (big-endian shift-in).
    generate
        if (LEN_BYTES > 1) begin : g_len_multi
            logic [c_LEN_W-9:0] r_len_hi;

            // Keep the earlier LEN bytes; the newest byte comes straight from din.
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    r_len_hi <= '0;
                end else if (din_vld && (r_state == S_LEN)) begin
                    r_len_hi <= w_len_val[c_LEN_W-9:0];
                end
            end

            assign w_len_val = {r_len_hi, din};
        end else begin : g_len_single
            assign w_len_val = din;
        end
    endgenerate

    assign w_len_val32 = 32'(w_len_val);
    assign w_len_last  = (r_len_idx == c_LIDX_LAST);
    assign state_c     = r_state;

    // Field walk: decide the next state and flag frame end / abort for this byte.
    always_comb begin
        w_state_nxt = r_state;
        w_abort     = 1'b0;
        w_fcs_last  = 1'b0;
        if (din_vld) begin
            case (r_state)
                S_HEAD: begin
                    if (w_sfd_hit) begin
                        w_state_nxt = S_TYPE;
                    end
                end
                S_TYPE: begin
                    w_state_nxt = (din == 8'h00) ? S_DATA : S_LEN;
                end
                S_LEN: begin
                    if (w_len_last) begin
                        if (w_len_val32 > c_MAX_LEN) begin
                            w_state_nxt = S_HEAD;
                            w_abort     = 1'b1;
                        end else if (w_len_val32 == 32'd0) begin
                            w_state_nxt = S_FCS;
                        end else begin
                            w_state_nxt = S_DATA;
                        end
                    end
                end
                S_DATA: begin
                    if (r_remaining == 16'd1) begin
                        w_state_nxt = S_FCS;
                    end
                end
                S_FCS: begin
                    if (r_fcs_idx == c_FIDX_LAST) begin
                        w_state_nxt = S_HEAD;
                        w_fcs_last  = 1'b1;
                    end
                end
                default: begin
                    w_state_nxt = S_HEAD;
                end
            endcase
        end
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_HEAD;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Field counters; the FCS index is cleared on every byte that can lead into FCS.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_len_idx   <= '0;
            r_fcs_idx   <= '0;
            r_remaining <= '0;
        end else if (din_vld) begin
            case (r_state)
                S_TYPE: begin
                    r_len_idx <= '0;
                    if (din == 8'h00) begin
                        r_remaining <= c_CTRL_LEN;
                    end
                end
                S_LEN: begin
                    r_len_idx <= r_len_idx + c_LIDX_W'(1);
                    r_fcs_idx <= '0;
                    if (w_len_last) begin
                        r_remaining <= 16'(w_len_val);
                    end
                end
                S_DATA: begin
                    r_remaining <= r_remaining - 16'd1;
                    r_fcs_idx   <= '0;
                end
                S_FCS: begin
                    r_fcs_idx <= r_fcs_idx + c_FIDX_W'(1);
                end
                default: begin
                end
            endcase
        end
    end

    // Registered output stage: one cycle behind the sampled byte; pulses drop on stalls.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dout     <= '0;
            dout_vld <= 1'b0;
            dout_sop <= 1'b0;
            dout_eop <= 1'b0;
            dout_err <= 1'b0;
            pkt_cnt  <= '0;
        end else if (din_vld) begin
            dout     <= din;
            dout_vld <= (r_state != S_HEAD);
            dout_sop <= (r_state == S_TYPE);
            dout_eop <= w_fcs_last || w_abort;
            dout_err <= w_abort;
            if (w_fcs_last) begin
                pkt_cnt <= pkt_cnt + 16'd1;
            end
        end else begin
            dout_vld <= 1'b0;
            dout_sop <= 1'b0;
            dout_eop <= 1'b0;
            dout_err <= 1'b0;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_pkt_parser_gen.sv
`default_nettype none
// ============================================================================
// Module   : tb_pkt_parser_gen
// Brief    : Self-checking bench for pkt_parser_gen. Frames are built at the
//            field level; each input byte carries its expected output framing
//            and resulting state, which a small model turns into per-cycle
//            expectations.
// Revision : 1.0 - initial release
// ============================================================================
module tb_pkt_parser_gen;

    localparam int c_PRE_NUM = 7;
    localparam int c_CTRL    = 64;
    localparam int c_FCS     = 4;
    localparam int c_MAX     = 1500;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [7:0]  din = 8'h00;
    logic        din_vld = 1'b0;
    logic [2:0]  state_c;
    logic [7:0]  dout;
    logic        dout_vld;
    logic        dout_sop;
    logic        dout_eop;
    logic        dout_err;
    logic [15:0] pkt_cnt;

    pkt_parser_gen #(
        .PRE_NUM      (c_PRE_NUM),
        .PRE_BYTE     (8'h55),
        .SFD_BYTE     (8'hD5),
        .LEN_BYTES    (2),
        .FCS_BYTES    (c_FCS),
        .CTRL_PKT_LEN (c_CTRL),
        .MAX_LEN      (c_MAX)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .din      (din),
        .din_vld  (din_vld),
        .state_c  (state_c),
        .dout     (dout),
        .dout_vld (dout_vld),
        .dout_sop (dout_sop),
        .dout_eop (dout_eop),
        .dout_err (dout_err),
        .pkt_cnt  (pkt_cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] b;
        bit         fwd;
        bit         sop;
        bit         eop;
        bit         err;
        logic [2:0] nst;
    } ent_t;

    ent_t q[$];

    // Annotation of the byte currently on din.
    bit         a_fwd, a_sop, a_eop, a_err;
    logic [2:0] a_nst;

    // Model of the registered outputs.
    logic [7:0]  m_dout;
    bit          m_vld, m_sop, m_eop, m_err;
    logic [2:0]  m_state;
    logic [15:0] m_cnt;

    int n_checks = 0;
    int n_fail   = 0;
    int n_vld, n_sop, n_eop, n_err;
    int good_built;
    bit chk_en = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_dout = 8'h00; m_vld = 0; m_sop = 0; m_eop = 0; m_err = 0;
            m_state = 3'd0; m_cnt = 16'd0;
        end else if (din_vld) begin
            m_dout  = din;
            m_vld   = a_fwd;
            m_sop   = a_sop;
            m_eop   = a_eop;
            m_err   = a_err;
            m_state = a_nst;
            if (a_eop && !a_err) m_cnt = m_cnt + 16'd1;
        end else begin
            m_vld = 0; m_sop = 0; m_eop = 0; m_err = 0;
        end
    end

    always @(negedge clk) begin
        if (rst_n && chk_en) begin
            check("dout",     32'(dout),     32'(m_dout));
            check("dout_vld", 32'(dout_vld), 32'(m_vld));
            check("dout_sop", 32'(dout_sop), 32'(m_sop));
            check("dout_eop", 32'(dout_eop), 32'(m_eop));
            check("dout_err", 32'(dout_err), 32'(m_err));
            check("state_c",  32'(state_c),  32'(m_state));
            check("pkt_cnt",  32'(pkt_cnt),  32'(m_cnt));
            if (dout_vld) n_vld++;
            if (dout_sop) n_sop++;
            if (dout_eop) n_eop++;
            if (dout_err) n_err++;
        end
    end

    function automatic void push(input logic [7:0] b, input bit fwd, input bit sop,
                                 input bit eop, input bit err, input logic [2:0] nst);
        ent_t e;
        e.b = b; e.fwd = fwd; e.sop = sop; e.eop = eop; e.err = err; e.nst = nst;
        q.push_back(e);
    endfunction

    // Field-level frame builder: preamble, SFD, TYPE, LEN, DATA, FCS.
    function automatic void build_frame(input int pre_n, input logic [7:0] typ, input int len);
        int ndata;
        for (int i = 0; i < pre_n; i++) push(8'h55, 0, 0, 0, 0, 3'd0);
        if (pre_n < c_PRE_NUM) begin
            push(8'hD5, 0, 0, 0, 0, 3'd0);
            return;
        end
        push(8'hD5, 0, 0, 0, 0, 3'd1);
        push(typ, 1, 1, 0, 0, (typ == 8'h00) ? 3'd3 : 3'd2);
        if (typ == 8'h00) begin
            ndata = c_CTRL;
        end else begin
            push(8'(len >> 8), 1, 0, 0, 0, 3'd2);
            if (len > c_MAX) begin
                push(8'(len), 1, 0, 1, 1, 3'd0);
                return;
            end
            push(8'(len), 1, 0, 0, 0, (len == 0) ? 3'd4 : 3'd3);
            ndata = len;
        end
        for (int i = 0; i < ndata; i++)
            push(8'($urandom), 1, 0, 0, 0, (i == ndata - 1) ? 3'd4 : 3'd3);
        for (int i = 0; i < c_FCS; i++)
            push(8'($urandom), 1, 0, (i == c_FCS - 1), 0, (i == c_FCS - 1) ? 3'd0 : 3'd4);
        good_built++;
    endfunction

    function automatic void push_junk(input int n);
        logic [7:0] b;
        for (int i = 0; i < n; i++) begin
            do b = 8'($urandom); while (b == 8'h55 || b == 8'hD5);
            push(b, 0, 0, 0, 0, 3'd0);
        end
    endfunction

    task automatic drive(input ent_t e);
        @(negedge clk);
        din = e.b; din_vld = 1'b1;
        a_fwd = e.fwd; a_sop = e.sop; a_eop = e.eop; a_err = e.err; a_nst = e.nst;
    endtask

    task automatic stall1();
        @(negedge clk);
        din = 8'($urandom); din_vld = 1'b0;
    endtask

    // mode 0: no stalls, 1: one stall before every byte, 2: random stall bursts.
    task automatic play(input int mode, input int cut);
        int n = 0;
        while (q.size() > 0 && (cut < 0 || n < cut)) begin
            if (mode == 1) stall1();
            else if (mode == 2 && $urandom_range(0, 3) == 0) repeat ($urandom_range(1, 3)) stall1();
            drive(q.pop_front());
            n++;
        end
    endtask

    task automatic settle();
        repeat (3) stall1();
        @(posedge clk);
        #2;
    endtask

    task automatic zero_cnt();
        n_vld = 0; n_sop = 0; n_eop = 0; n_err = 0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1, "watchdog");
    end

    initial begin
        good_built = 0;
        zero_cnt();
        repeat (2) @(negedge clk);
        check("rst_state",   32'(state_c),  32'd0);
        check("rst_dout",    32'(dout),     32'd0);
        check("rst_vld",     32'(dout_vld), 32'd0);
        check("rst_pkt_cnt", 32'(pkt_cnt),  32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        chk_en = 1'b1;

        // Control frame.
        zero_cnt();
        build_frame(7, 8'h00, 0);
        play(0, -1);
        settle();
        check("t1_vld_cycles", 32'(n_vld), 32'd69);
        check("t1_sop_cnt",    32'(n_sop), 32'd1);
        check("t1_eop_cnt",    32'(n_eop), 32'd1);
        check("t1_pkt_cnt",    32'(pkt_cnt), 32'd1);

        // Length-5 frame with alternating stalls.
        zero_cnt();
        build_frame(8, 8'h01, 5);
        play(1, -1);
        settle();
        check("t2_vld_cycles", 32'(n_vld), 32'd12);
        check("t2_eop_cnt",    32'(n_eop), 32'd1);
        check("t2_pkt_cnt",    32'(pkt_cnt), 32'd2);

        // Short preamble rejected, then a good control frame.
        zero_cnt();
        build_frame(6, 8'h00, 0);
        build_frame(7, 8'h00, 0);
        play(2, -1);
        settle();
        check("t3_vld_cycles", 32'(n_vld), 32'd69);
        check("t3_pkt_cnt",    32'(pkt_cnt), 32'd3);

        // Oversize LEN abort.
        zero_cnt();
        build_frame(7, 8'h02, 1792);
        play(0, -1);
        settle();
        check("t4_vld_cycles", 32'(n_vld), 32'd3);
        check("t4_err_cnt",    32'(n_err), 32'd1);
        check("t4_eop_cnt",    32'(n_eop), 32'd1);
        check("t4_state",      32'(state_c), 32'd0);
        check("t4_pkt_cnt",    32'(pkt_cnt), 32'd3);

        // Zero-length data frame.
        zero_cnt();
        build_frame(7, 8'h03, 0);
        play(0, -1);
        settle();
        check("t5_vld_cycles", 32'(n_vld), 32'd7);
        check("t5_pkt_cnt",    32'(pkt_cnt), 32'd4);

        // Asynchronous reset during DATA byte 10 of a control frame.
        build_frame(7, 8'h00, 0);
        play(0, 19);
        #2;
        check("t6_pre_vld", 32'(dout_vld), 32'd1);
        rst_n = 1'b0;
        #1;
        check("t6_rst_vld",   32'(dout_vld), 32'd0);
        check("t6_rst_dout",  32'(dout),     32'd0);
        check("t6_rst_state", 32'(state_c),  32'd0);
        check("t6_rst_eop",   32'(dout_eop), 32'd0);
        check("t6_rst_pkt",   32'(pkt_cnt),  32'd0);
        q.delete();
        @(negedge clk);
        din_vld = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        zero_cnt();
        build_frame(7, 8'h00, 0);
        play(0, -1);
        settle();
        check("t6_vld_cycles", 32'(n_vld), 32'd69);
        check("t6_pkt_cnt",    32'(pkt_cnt), 32'd1);

        // Randomised traffic with stalls, junk, rejects, aborts and edge lengths.
        good_built = 0;
        for (int i = 0; i < 40; i++) begin
            int kind;
            int pre_n;
            logic [7:0] typ;
            kind  = $urandom_range(0, 9);
            pre_n = $urandom_range(7, 12);
            do typ = 8'($urandom); while (typ == 8'h00);
            push_junk($urandom_range(0, 3));
            if (i == 5)          build_frame(pre_n, typ, 1500);
            else if (kind == 0)  build_frame($urandom_range(1, 6), 8'h00, 0);
            else if (kind == 1)  build_frame(pre_n, typ, $urandom_range(1501, 65535));
            else if (kind == 2)  build_frame(pre_n, 8'h00, 0);
            else if (kind == 3)  build_frame(pre_n, typ, 0);
            else                 build_frame(pre_n, typ, $urandom_range(1, 60));
            play(2, -1);
        end
        settle();
        check("rand_pkt_cnt", 32'(pkt_cnt), 32'(1 + good_built));

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
